// File: rtl/data_bus_responder.sv
// Responder for the processor data-memory bus: on-chip RAM plus a 4-word I/O page
// (TX FIFO push, status/W1C flags, free-running cycle counter, cycle counter load).
module data_bus_responder #(
  parameter int                   ADDR_SIZE  = 18,
  parameter int                   WORD_SIZE  = 18,
  parameter int                   MEM_SIZE   = 1024,
  parameter logic [ADDR_SIZE-1:0] IO_BASE    = 18'h3FF00,
  parameter int                   FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 memory_write_enable,
  input  logic [ADDR_SIZE-1:0] memory_addr,
  input  logic [WORD_SIZE-1:0] memory_in,
  output logic [WORD_SIZE-1:0] memory_out,
  output logic                 tx_valid,
  output logic [WORD_SIZE-1:0] tx_data,
  input  logic                 tx_ready
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RAW = $clog2(MEM_SIZE);

  localparam logic [ADDR_SIZE-1:0] IO_TX  = IO_BASE;
  localparam logic [ADDR_SIZE-1:0] IO_ST  = IO_BASE + ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] IO_CYC = IO_BASE + ADDR_SIZE'(2);
  localparam logic [ADDR_SIZE-1:0] IO_LD  = IO_BASE + ADDR_SIZE'(3);

  typedef struct packed {
    logic ram;
    logic tx;
    logic st;
    logic cyc;
    logic ld;
  } sel_t;

  sel_t                 sel;
  logic                 unmapped;
  logic [RAW-1:0]       ram_idx;
  logic [WORD_SIZE-1:0] ram [MEM_SIZE];

  logic [WORD_SIZE-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, count_n;
  logic                 full, push_req, push, pop, ovf_set, err_set, w1c;
  logic                 overflow, bus_error;
  logic [WORD_SIZE-1:0] cycle, status;

  always_comb begin
    sel.ram  = memory_addr < ADDR_SIZE'(MEM_SIZE);
    sel.tx   = memory_addr == IO_TX;
    sel.st   = memory_addr == IO_ST;
    sel.cyc  = memory_addr == IO_CYC;
    sel.ld   = memory_addr == IO_LD;
    unmapped = (sel == '0);
  end

  assign ram_idx  = memory_addr[RAW-1:0];
  assign full     = count == CW'(FIFO_DEPTH);
  assign tx_valid = count != '0;
  assign tx_data  = fifo[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  assign push_req = memory_write_enable & sel.tx;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign err_set  = memory_write_enable & unmapped;
  assign w1c      = memory_write_enable & sel.st;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + CW'(1);
    else if (pop && !push) count_n = count - CW'(1);
  end

  always_comb begin
    status     = '0;
    status[11] = bus_error;
    status[10] = overflow;
    status[9]  = full;
    status[8]  = ~tx_valid;
    status[7:0] = 8'(count);
  end

  always_comb begin
    memory_out = '0;
    if (sel.ram)      memory_out = ram[ram_idx];
    else if (sel.st)  memory_out = status;
    else if (sel.cyc) memory_out = cycle;
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clock) begin
    if (memory_write_enable && sel.ram) ram[ram_idx] <= memory_in;
    if (push)                           fifo[wr_ptr] <= memory_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cycle     <= '0;
      overflow  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      cycle <= (memory_write_enable && sel.ld) ? memory_in : cycle + WORD_SIZE'(1);
      // Set beats a simultaneous write-1-to-clear.
      overflow  <= ovf_set | (overflow  & ~(w1c & memory_in[10]));
      bus_error <= err_set | (bus_error & ~(w1c & memory_in[11]));
    end
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: load expectations and TX stream words are
// queued by the stimulus and checked by a negedge monitor.
module tb_data_bus_responder;
  localparam logic [17:0] IO_TX  = 18'h3FF00;
  localparam logic [17:0] IO_ST  = 18'h3FF01;
  localparam logic [17:0] IO_CYC = 18'h3FF02;
  localparam logic [17:0] IO_LD  = 18'h3FF03;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memory_write_enable = 1'b0;
  logic [17:0] memory_addr = '0;
  logic [17:0] memory_in = '0;
  logic [17:0] memory_out;
  logic        tx_valid;
  logic [17:0] tx_data;
  logic        tx_ready = 1'b0;

  typedef struct {
    string       name;
    logic [17:0] val;
  } exp_t;

  exp_t        rd_q[$];
  logic [17:0] tx_q[$];
  exp_t        e;
  logic [17:0] te;
  logic        chk = 1'b0;
  logic        fin = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  data_bus_responder dut (
    .clock(clock), .reset(reset), .memory_write_enable(memory_write_enable),
    .memory_addr(memory_addr), .memory_in(memory_in), .memory_out(memory_out),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  task automatic op(input logic we, input logic [17:0] a, input logic [17:0] d);
    @(posedge clock); #1;
    memory_write_enable = we; memory_addr = a; memory_in = d; chk = 1'b0;
  endtask

  task automatic ld(input logic [17:0] a, input logic [17:0] v, input string n);
    exp_t x;
    @(posedge clock); #1;
    memory_write_enable = 1'b0; memory_addr = a; memory_in = '0; chk = 1'b1;
    x.name = n; x.val = v;
    rd_q.push_back(x);
  endtask

  always @(negedge clock) begin
    if (chk) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_underflow: no expectation queued, memory_out=%h", memory_out);
      end else begin
        e = rd_q.pop_front();
        if (memory_out !== e.val) begin
          n_bad++;
          $display("FAIL %s: memory_out=%h expected %h", e.name, memory_out, e.val);
        end
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_bad++;
        $display("FAIL tx_unexpected: tx_data=%h with nothing queued", tx_data);
      end else begin
        te = tx_q.pop_front();
        if (tx_data !== te) begin
          n_bad++;
          $display("FAIL tx_data: got %h expected %h", tx_data, te);
        end
      end
    end
    if (fin) begin
      n_cmp++;
      if (tx_q.size() != 0 || rd_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover: tx_q=%0d rd_q=%0d expected 0/0", tx_q.size(), rd_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then counter counting up from 0.
    repeat (2) @(posedge clock);
    ld(IO_ST, 18'h00100, "rst_status");
    ld(IO_CYC, 18'h00000, "rst_cycle");
    reset = 1'b0;
    ld(IO_CYC, 18'h00001, "cycle_1");
    ld(IO_CYC, 18'h00002, "cycle_2");
    ld(IO_TX, 18'h00000, "txdata_reads0");
    ld(IO_LD, 18'h00000, "cycld_reads0");
    ld(18'h3FF04, 18'h00000, "unmapped_read");

    // RAM store/load and out-of-range read.
    op(1'b1, 18'd5, 18'h2A5A5);
    op(1'b1, 18'd0, 18'h00777);
    ld(18'd5, 18'h2A5A5, "ram5");
    ld(18'd1024, 18'h00000, "ram_oor");
    ld(IO_ST, 18'h00100, "no_rd_buserr");

    // Fill FIFO, overflow, drain in order.
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, IO_TX, 18'(i));
      tx_q.push_back(18'(i));
    end
    ld(IO_ST, 18'h00208, "full_status");
    op(1'b1, IO_TX, 18'd9);
    ld(IO_ST, 18'h00608, "overflow_status");
    tx_ready = 1'b1;
    repeat (10) op(1'b0, 18'd0, 18'd0);
    ld(IO_ST, 18'h00500, "drained_status");

    // Push and pop together while full.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op(1'b1, IO_TX, 18'h21 + 18'(i));
      tx_q.push_back(18'h21 + 18'(i));
    end
    op(1'b1, IO_ST, 18'h00400);
    ld(IO_ST, 18'h00208, "w1c_ovf_full");
    op(1'b1, IO_TX, 18'h00011);
    tx_q.push_back(18'h00011);
    tx_ready = 1'b1;
    op(1'b0, 18'd0, 18'd0);
    tx_ready = 1'b0;
    ld(IO_ST, 18'h00208, "pushpop_full");
    tx_ready = 1'b1;
    repeat (10) op(1'b0, 18'd0, 18'd0);
    ld(IO_ST, 18'h00100, "drained2_status");

    // Unmapped store flags bus_error and leaves RAM alone; W1C clears.
    op(1'b1, 18'h20000, 18'h01234);
    ld(IO_ST, 18'h00900, "buserr_status");
    ld(18'd0, 18'h00777, "ram0_unchanged");
    op(1'b1, IO_ST, 18'h00C00);
    ld(IO_ST, 18'h00100, "w1c_both");

    // Cycle counter load and wrap.
    op(1'b1, IO_LD, 18'h3FFFF);
    ld(IO_CYC, 18'h3FFFF, "cycle_loaded");
    ld(IO_CYC, 18'h00000, "cycle_wrap");
    ld(IO_CYC, 18'h00001, "cycle_after_wrap");

    // Reset mid-stream discards queued words.
    tx_ready = 1'b0;
    op(1'b1, IO_TX, 18'h00031);
    op(1'b1, IO_TX, 18'h00032);
    op(1'b1, IO_TX, 18'h00033);
    op(1'b0, 18'd0, 18'd0);
    reset = 1'b1;
    ld(IO_ST, 18'h00100, "midrst_status");
    ld(IO_CYC, 18'h00000, "midrst_cycle");
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (4) op(1'b0, 18'd0, 18'd0);
    ld(IO_ST, 18'h00100, "post_rst_status");
    op(1'b0, 18'd0, 18'd0);
    fin = 1'b1;
  end
endmodule
